// File: rtl/greenhouse_pkg.sv
// Shared greenhouse definitions: controller state encoding, humidity full scale
// and the default ADC wait limit.
package greenhouse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ADC,
        S_CONV,
        S_ACCUM,
        S_UPDATE
    } state_t;

    localparam logic [9:0] HUM_MAX         = 10'd1000;
    localparam int         ADC_TIMEOUT_DEF = 255;

endpackage

// File: rtl/hysteresis_comparator.sv
// Saturating lo/hi band around the setpoint and the set/clear/hold decision
// for the mister relay.
module hysteresis_comparator
    import greenhouse_pkg::*;
(
    input  logic [9:0] avg,
    input  logic [9:0] setpoint,
    input  logic [6:0] hysteresis,
    input  logic       on_cur,
    output logic       on_next
);

    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [6:0] b);
        if ({3'b000, b} > a)
            return 10'd0;
        else
            return a - {3'b000, b};
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [6:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {4'b0000, b};
        if (s > {1'b0, HUM_MAX})
            return HUM_MAX;
        else
            return s[9:0];
    endfunction

    logic [9:0] lo;
    logic [9:0] hi;

    always_comb begin
        lo      = sat_sub(setpoint, hysteresis);
        hi      = sat_add(setpoint, hysteresis);
        on_next = on_cur;
        if (avg < lo)
            on_next = 1'b1;
        else if (avg > hi)
            on_next = 1'b0;
    end

endmodule

// File: rtl/humidity_sample_controller.sv
// Periodic humidity measurement: averages 2^N_AVG_LOG2 ADC samples through an
// external voltage-to-humidity converter and drives the mister with hysteresis.
module humidity_sample_controller
    import greenhouse_pkg::*;
#(
    parameter int N_AVG_LOG2  = 2,
    parameter int ADC_TIMEOUT = ADC_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    output logic [11:0] conv_voltage,
    input  logic [9:0]  conv_humidity,
    input  logic [9:0]  setpoint,
    input  logic [6:0]  hysteresis,
    output logic [9:0]  humidity_avg,
    output logic        avg_valid,
    output logic        mister_on,
    output logic        busy,
    output logic        timeout_err
);

    localparam int SUM_W = 10 + N_AVG_LOG2;
    localparam int CNT_W = N_AVG_LOG2 + 1;
    localparam int TW    = $clog2(ADC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << N_AVG_LOG2) - 1);

    state_t           state;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [TW-1:0]    tcnt;
    logic [9:0]       avg_new;
    logic             mister_next;

    assign avg_new = 10'(sum >> N_AVG_LOG2);
    assign busy    = (state != S_IDLE);

    hysteresis_comparator u_cmp (
        .avg        (avg_new),
        .setpoint   (setpoint),
        .hysteresis (hysteresis),
        .on_cur     (mister_on),
        .on_next    (mister_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sum          <= '0;
            cnt          <= '0;
            tcnt         <= '0;
            adc_start    <= 1'b0;
            conv_voltage <= '0;
            humidity_avg <= '0;
            avg_valid    <= 1'b0;
            mister_on    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            avg_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        state     <= S_START;
                        adc_start <= 1'b1;
                    end
                end
                S_START: begin
                    tcnt  <= '0;
                    state <= S_WAIT_ADC;
                end
                S_WAIT_ADC: begin
                    if (adc_done) begin
                        conv_voltage <= adc_data;
                        tcnt         <= '0;
                        state        <= S_CONV;
                    end else if (tcnt == TW'(ADC_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        mister_on   <= 1'b0;
                        sum         <= '0;
                        cnt         <= '0;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                // tcnt is reused to give the converter its two-cycle settle
                S_CONV: begin
                    if (tcnt == TW'(1))
                        state <= S_ACCUM;
                    else
                        tcnt <= tcnt + 1'b1;
                end
                S_ACCUM: begin
                    sum <= sum + SUM_W'(conv_humidity);
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_SAMPLE) begin
                        state <= S_UPDATE;
                    end else begin
                        state     <= S_START;
                        adc_start <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    humidity_avg <= avg_new;
                    avg_valid    <= 1'b1;
                    mister_on    <= mister_next;
                    timeout_err  <= 1'b0;
                    sum          <= '0;
                    cnt          <= '0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_humidity_sample_controller.sv
// Randomized bench for humidity_sample_controller with an external converter
// model and a measurement-level reference model.
module tb_humidity_sample_controller;

    localparam int NS      = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        adc_start;
    logic        adc_done;
    logic [11:0] adc_data;
    logic [11:0] conv_voltage;
    logic [9:0]  conv_humidity;
    logic [9:0]  setpoint;
    logic [6:0]  hysteresis;
    logic [9:0]  humidity_avg;
    logic        avg_valid;
    logic        mister_on;
    logic        busy;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    bit model_on = 1'b0;

    humidity_sample_controller dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .adc_start     (adc_start),
        .adc_done      (adc_done),
        .adc_data      (adc_data),
        .conv_voltage  (conv_voltage),
        .conv_humidity (conv_humidity),
        .setpoint      (setpoint),
        .hysteresis    (hysteresis),
        .humidity_avg  (humidity_avg),
        .avg_valid     (avg_valid),
        .mister_on     (mister_on),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Sensor transfer: 2 codes per 0.1 %RH above an offset of 2009, clamped 0..1000
    function automatic int conv_fn(input logic [11:0] v);
        int h;
        if (int'(v) < 2009) return 0;
        h = (int'(v) - 2009) / 2;
        return (h > 1000) ? 1000 : h;
    endfunction

    always_ff @(posedge clk) conv_humidity <= 10'(conv_fn(conv_voltage));

    always @(negedge clk) if (adc_start === 1'b1) n_start = n_start + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (adc_start) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic answer(input logic [11:0] v);
        int d;
        d = $urandom_range(1, 8);
        // A tick during START must be ignored
        sample_tick = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (d - 1) @(negedge clk);
        adc_data = v;
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
        adc_data = 12'($urandom);
    endtask

    task automatic run_meas(input logic [11:0] v0, v1, v2, v3);
        logic [11:0] v[4];
        int hsum, avg, lo, hi, base;
        bit got;
        v = '{v0, v1, v2, v3};
        base = n_start;
        hsum = 0;
        pulse_tick();
        for (int s = 0; s < NS; s++) begin
            wait_start(got);
            check("adc_start_seen", int'(got), 1);
            answer(v[s]);
            hsum += conv_fn(v[s]);
        end
        avg = hsum / NS;
        lo  = int'(setpoint) - int'(hysteresis);
        if (lo < 0) lo = 0;
        hi  = int'(setpoint) + int'(hysteresis);
        if (hi > 1000) hi = 1000;
        if (avg < lo) model_on = 1'b1;
        else if (avg > hi) model_on = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (avg_valid) got = 1'b1;
            else @(negedge clk);
        end
        check("avg_valid_seen", int'(got), 1);
        check("humidity_avg", int'(humidity_avg), avg);
        check("mister_on", int'(mister_on), int'(model_on));
        check("timeout_err_clr", int'(timeout_err), 0);
        check("busy_after", int'(busy), 0);
        check("starts_per_meas", n_start - base, NS);
        @(negedge clk);
        check("avg_valid_pulse", int'(avg_valid), 0);
    endtask

    initial begin
        bit got;
        int el;
        rst = 1'b1;
        sample_tick = 1'b0;
        adc_done = 1'b0;
        adc_data = '0;
        setpoint = 10'd600;
        hysteresis = 7'd20;
        repeat (3) @(negedge clk);
        check("rst_adc_start", int'(adc_start), 0);
        check("rst_conv_voltage", int'(conv_voltage), 0);
        check("rst_humidity_avg", int'(humidity_avg), 0);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_mister_on", int'(mister_on), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Below band -> mister on; in band -> hold; above band -> off
        run_meas(12'h83E, 12'h83E, 12'h83E, 12'h83E);
        check("dir_avg50", int'(humidity_avg), 50);
        check("dir_on_set", int'(mister_on), 1);
        run_meas(12'hC89, 12'hC89, 12'hC89, 12'hC89);
        check("dir_on_hold", int'(mister_on), 1);
        run_meas(12'hCBB, 12'hCBB, 12'hCBB, 12'hCBB);
        check("dir_avg625", int'(humidity_avg), 625);
        check("dir_on_clr", int'(mister_on), 0);

        // ADC timeout with the mister running
        run_meas(12'h83E, 12'h83E, 12'h83E, 12'h83E);
        pulse_tick();
        wait_start(got);
        check("to_start_seen", int'(got), 1);
        el = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            @(negedge clk);
            el++;
        end
        check("to_latency", el, TIMEOUT + 1);
        check("to_err_set", int'(timeout_err), 1);
        check("to_mister_clr", int'(mister_on), 0);
        check("to_busy", int'(busy), 0);
        model_on = 1'b0;
        run_meas(12'hC89, 12'hC89, 12'hC89, 12'hC89);

        // Saturated band edges
        setpoint = 10'd10;
        hysteresis = 7'd50;
        run_meas(12'h000, 12'h000, 12'h000, 12'h000);
        check("lo_sat_no_set", int'(mister_on), 0);
        setpoint = 10'd600;
        hysteresis = 7'd20;
        run_meas(12'h000, 12'h000, 12'h000, 12'h000);
        setpoint = 10'd990;
        hysteresis = 7'd50;
        run_meas(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        check("hi_sat_avg", int'(humidity_avg), 1000);
        check("hi_sat_no_clr", int'(mister_on), 1);

        // Reset while waiting on the second sample, then a late adc_done
        setpoint = 10'd600;
        hysteresis = 7'd20;
        pulse_tick();
        wait_start(got);
        answer(12'h900);
        wait_start(got);
        check("rst_mid_start", int'(got), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_adc_start", int'(adc_start), 0);
        check("mid_conv_voltage", int'(conv_voltage), 0);
        check("mid_humidity_avg", int'(humidity_avg), 0);
        check("mid_avg_valid", int'(avg_valid), 0);
        check("mid_mister_on", int'(mister_on), 0);
        check("mid_timeout_err", int'(timeout_err), 0);
        check("mid_busy", int'(busy), 0);
        el = n_start;
        adc_data = 12'hABC;
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
        repeat (3) @(negedge clk);
        check("late_done_ign_v", int'(conv_voltage), 0);
        check("late_done_busy", int'(busy), 0);
        check("late_done_starts", n_start - el, 0);
        model_on = 1'b0;
        run_meas(12'($urandom_range(1900, 4095)), 12'($urandom_range(1900, 4095)),
                 12'($urandom_range(1900, 4095)), 12'($urandom_range(1900, 4095)));

        for (int k = 0; k < 10; k++) begin
            setpoint = 10'($urandom_range(0, 1023));
            hysteresis = 7'($urandom_range(0, 127));
            run_meas(12'($urandom_range(1900, 4095)), 12'($urandom_range(1900, 4095)),
                     12'($urandom_range(1900, 4095)), 12'($urandom_range(1900, 4095)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
